// File: rtl/cic_interp_norm.sv
// CIC interpolator extension/normalisation stage: sign-extends narrow samples to the
// accumulator width and rescales wide integrator output back to bw bits by a rate-derived shift.
module cic_interp_norm #(
    parameter int bw               = 16,
    parameter int N                = 4,
    parameter int log2_of_max_rate = 7
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         strobe,
    input  logic [7:0]                                   rate,
    input  logic [bw-1:0]                                narrow_in,
    input  logic [bw+(N-1)*log2_of_max_rate-1:0]         wide_in,
    output logic [bw+(N-1)*log2_of_max_rate-1:0]         ext_out,
    output logic [bw-1:0]                                norm_out,
    output logic                                         valid_out
);

    localparam int maxbitgain = (N - 1) * log2_of_max_rate;
    localparam int W          = bw + maxbitgain;
    localparam int SW         = $clog2(maxbitgain + 1);

    // Smallest g with r^(N-1) <= 2^g, clamped to maxbitgain. The running power
    // saturates just above the clamp so it never overflows for any N.
    function automatic int calc_shift(input int r);
        logic [63:0] lim;
        logic [63:0] p;
        int          result;
        lim = 64'd1 << maxbitgain;
        p   = 64'd1;
        for (int k = 0; k < N - 1; k++) begin
            p = p * 64'(r);
            if (p > lim) p = lim + 64'd1;
        end
        result = maxbitgain;
        for (int g = maxbitgain; g >= 0; g--) begin
            if (p <= (64'd1 << g)) result = g;
        end
        if (r > (1 << log2_of_max_rate)) result = maxbitgain;
        return result;
    endfunction

    logic [SW-1:0] shift_table [256];

    genvar gr;
    generate
        for (gr = 0; gr < 256; gr++) begin : g_shift
            localparam int S = calc_shift(gr);
            assign shift_table[gr] = S[SW-1:0];
        end
    endgenerate

    logic [SW-1:0] shift;
    logic [W-1:0]  ext_d,   ext_q;
    logic [bw-1:0] norm_d,  norm_q;
    logic          valid_d, valid_q;

    assign shift = shift_table[rate];

    always_comb begin
        ext_d   = ext_q;
        norm_d  = norm_q;
        valid_d = strobe;
        if (strobe) begin
            ext_d  = {{maxbitgain{narrow_in[bw-1]}}, narrow_in};
            norm_d = wide_in[shift +: bw];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_q   <= '0;
            norm_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            norm_q  <= norm_d;
            valid_q <= valid_d;
        end
    end

    assign ext_out   = ext_q;
    assign norm_out  = norm_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_cic_interp_norm.sv
// Directed self-checking bench for cic_interp_norm: reset, sign extension,
// normalisation at exact/non-power-of-two rates, floor truncation and strobe gating.
module tb_cic_interp_norm;

    localparam int W = 37;

    logic          clock;
    logic          reset;
    logic          strobe;
    logic [7:0]    rate;
    logic [15:0]   narrow_in;
    logic [W-1:0]  wide_in;
    logic [W-1:0]  ext_out;
    logic [15:0]   norm_out;
    logic          valid_out;

    int total;
    int bad;

    cic_interp_norm dut (
        .clock     (clock),
        .reset     (reset),
        .strobe    (strobe),
        .rate      (rate),
        .narrow_in (narrow_in),
        .wide_in   (wide_in),
        .ext_out   (ext_out),
        .norm_out  (norm_out),
        .valid_out (valid_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the next rising edge.
    task automatic applyStimulus(input logic s, input logic [7:0] r,
                                 input logic [15:0] n, input logic [W-1:0] w);
        @(negedge clock);
        strobe    = s;
        rate      = r;
        narrow_in = n;
        wide_in   = w;
        @(posedge clock);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        strobe    = 1'b0;
        rate      = 8'd1;
        narrow_in = '0;
        wide_in   = '0;
        #1;
        checkOutput("rst_ext",   64'(ext_out),   64'h0);
        checkOutput("rst_norm",  64'(norm_out),  64'h0);
        checkOutput("rst_valid", 64'(valid_out), 64'h0);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus(1'b1, 8'd4, 16'h8000, 37'h13480);
        checkOutput("ext_neg",   64'(ext_out),   64'h1F_FFFF_8000);
        checkOutput("norm_r4",   64'(norm_out),  64'h04D2);
        checkOutput("valid_1",   64'(valid_out), 64'h1);

        applyStimulus(1'b1, 8'd128, 16'h7FFF, 37'h7FFF << 21);
        checkOutput("ext_pos",   64'(ext_out),   64'h00_0000_7FFF);
        checkOutput("norm_r128", 64'(norm_out),  64'h7FFF);

        applyStimulus(1'b1, 8'd1, 16'h0001, 37'h1234);
        checkOutput("norm_r1",   64'(norm_out),  64'h1234);
        checkOutput("ext_one",   64'(ext_out),   64'h1);

        applyStimulus(1'b1, 8'd0, 16'h0001, 37'h1234);
        checkOutput("norm_r0",   64'(norm_out),  64'h1234);

        applyStimulus(1'b1, 8'd5, 16'h0001, 37'h80);
        checkOutput("norm_r5",   64'(norm_out),  64'h0001);

        applyStimulus(1'b1, 8'd3, 16'h0001, 37'h20);
        checkOutput("norm_r3",   64'(norm_out),  64'h0001);

        applyStimulus(1'b1, 8'd101, 16'h0001, 37'h1 << 20);
        checkOutput("norm_r101", 64'(norm_out),  64'h0001);

        applyStimulus(1'b1, 8'd102, 16'h0001, 37'h1 << 20);
        checkOutput("norm_r102", 64'(norm_out),  64'h0000);

        applyStimulus(1'b1, 8'd200, 16'h0001, 37'h7FFF << 21);
        checkOutput("norm_r200", 64'(norm_out),  64'h7FFF);

        applyStimulus(1'b1, 8'd4, 16'h0001, W'(-64));
        checkOutput("norm_m64",  64'(norm_out),  64'hFFFF);

        applyStimulus(1'b1, 8'd4, 16'h7FFF, W'(-65));
        checkOutput("norm_m65",  64'(norm_out),  64'hFFFE);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'(i + 2), 16'(16'h8000 + i), 37'h1_2345_6789 + 37'(i));
            checkOutput("gate_ext",   64'(ext_out),   64'h7FFF);
            checkOutput("gate_norm",  64'(norm_out),  64'hFFFE);
            checkOutput("gate_valid", 64'(valid_out), 64'h0);
        end

        applyStimulus(1'b1, 8'd1, 16'h8001, 37'h55);
        checkOutput("pulse_valid", 64'(valid_out), 64'h1);
        checkOutput("pulse_ext",   64'(ext_out),   64'h1F_FFFF_8001);
        checkOutput("pulse_norm",  64'(norm_out),  64'h0055);
        applyStimulus(1'b0, 8'd1, 16'h0000, 37'h0);
        checkOutput("pulse_end",   64'(valid_out), 64'h0);
        checkOutput("pulse_hold",  64'(ext_out),   64'h1F_FFFF_8001);

        applyStimulus(1'b1, 8'd8, 16'h0002, 37'h9 << 9);
        checkOutput("norm_r8",     64'(norm_out),  64'h0009);
        @(negedge clock);
        strobe = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_ext",   64'(ext_out),   64'h0);
        checkOutput("mid_rst_norm",  64'(norm_out),  64'h0);
        checkOutput("mid_rst_valid", 64'(valid_out), 64'h0);
        @(posedge clock);
        #1;
        checkOutput("rst_hold_valid", 64'(valid_out), 64'h0);
        checkOutput("rst_hold_ext",   64'(ext_out),   64'h0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b1, 8'd4, 16'h1234, 37'h13480);
        checkOutput("post_rst_ext",   64'(ext_out),   64'h1234);
        checkOutput("post_rst_norm",  64'(norm_out),  64'h04D2);
        checkOutput("post_rst_valid", 64'(valid_out), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
